// File: rtl/reaction_score_keeper_if.sv
// Bundle of control inputs and score outputs between the test FSMs and the score keeper.
interface reaction_score_keeper_if #(
  parameter int unsigned W = 24
);
  logic         stop;
  logic [W-1:0] time_bcd;
  logic         clr_best;
  logic [2:0]   hist_sel;

  logic [W-1:0] last_bcd;
  logic [W-1:0] best_bcd;
  logic         best_valid;
  logic         new_best;
  logic         false_st;
  logic         bcd_err;
  logic [7:0]   attempts;
  logic [W-1:0] hist_bcd;
  logic         busy;

  modport master (
    output stop, time_bcd, clr_best, hist_sel,
    input  last_bcd, best_bcd, best_valid, new_best, false_st, bcd_err,
           attempts, hist_bcd, busy
  );

  modport slave (
    input  stop, time_bcd, clr_best, hist_sel,
    output last_bcd, best_bcd, best_valid, new_best, false_st, bcd_err,
           attempts, hist_bcd, busy
  );
endinterface

// File: rtl/reaction_score_keeper.sv
// Captures BCD reaction time on stop rise, rejects false starts / bad BCD, tracks best and attempts.
// Optional result history enabled by defining SCORE_HIST_EN; outputs appear 3 cycles after the stop edge.
module reaction_score_keeper #(
  parameter int unsigned          DIGITS     = 6,
  parameter logic [4*DIGITS-1:0]  MIN_TIME   = 24'h000100,
  parameter int unsigned          HIST_DEPTH = 4
) (
  input  logic                     clk50M,
  input  logic                     rst,
  reaction_score_keeper_if.slave   bus
);

  localparam int unsigned W = 4 * DIGITS;
  localparam logic [W-1:0] ALL9 = {DIGITS{4'h9}};

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_CHECK, S_UPDATE} state_t;

  state_t       state_q;
  logic         stop_q;
  logic [W-1:0] last_q;
  logic [W-1:0] best_q;
  logic         best_valid_q;
  logic         new_best_q;
  logic         false_st_q;
  logic         bcd_err_q;
  logic [7:0]   attempts_q;
  logic         busy_q;
  logic         err_q, fs_q, less_q;
  logic         err_d, fs_d, less_d;
  logic         capture_req;

  // Digit-wise less-than from the most significant digit down.
  function automatic logic bcd_lt(input logic [W-1:0] a, input logic [W-1:0] b);
    logic done;
    logic lt;
    done = 1'b0;
    lt   = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (!done && (a[4*i +: 4] != b[4*i +: 4])) begin
        lt   = (a[4*i +: 4] < b[4*i +: 4]);
        done = 1'b1;
      end
    end
    return lt;
  endfunction

  function automatic logic bcd_bad(input logic [W-1:0] a);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign capture_req = bus.stop & ~stop_q;

  always_comb begin
    err_d  = bcd_bad(last_q);
    fs_d   = bcd_lt(last_q, MIN_TIME) || (last_q == '0);
    less_d = bcd_lt(last_q, best_q);
  end

`ifdef SCORE_HIST_EN
  localparam int unsigned HW = $clog2(HIST_DEPTH);
  logic [W-1:0] hist_q [HIST_DEPTH];
  assign bus.hist_bcd = hist_q[bus.hist_sel[HW-1:0]];
`else
  localparam logic [3:0] HD_BITS = 4'(HIST_DEPTH);
  logic unused_hist;
  assign unused_hist  = ^{bus.hist_sel, HD_BITS};
  assign bus.hist_bcd = last_q;
`endif

  always_ff @(posedge clk50M) begin
    if (rst) begin
      state_q      <= S_IDLE;
      stop_q       <= 1'b0;
      last_q       <= '0;
      best_q       <= ALL9;
      best_valid_q <= 1'b0;
      new_best_q   <= 1'b0;
      false_st_q   <= 1'b0;
      bcd_err_q    <= 1'b0;
      attempts_q   <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      fs_q         <= 1'b0;
      less_q       <= 1'b0;
`ifdef SCORE_HIST_EN
      for (int i = 0; i < int'(HIST_DEPTH); i++) hist_q[i] <= '0;
`endif
    end else begin
      stop_q     <= bus.stop;
      new_best_q <= 1'b0;
      false_st_q <= 1'b0;
      bcd_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (capture_req) begin
            state_q <= S_CAPTURE;
            busy_q  <= 1'b1;
          end
        end
        S_CAPTURE: begin
          last_q  <= bus.time_bcd;
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          err_q   <= err_d;
          fs_q    <= fs_d;
          less_q  <= less_d;
          state_q <= S_UPDATE;
        end
        S_UPDATE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (err_q) begin
            bcd_err_q <= 1'b1;
          end else if (fs_q) begin
            false_st_q <= 1'b1;
          end else begin
            if (attempts_q != 8'hFF) attempts_q <= attempts_q + 8'd1;
`ifdef SCORE_HIST_EN
            for (int i = int'(HIST_DEPTH) - 1; i > 0; i--) hist_q[i] <= hist_q[i-1];
            hist_q[0] <= last_q;
`endif
            // A concurrent clear suppresses the best update but not the count/history.
            if (!bus.clr_best && (less_q || !best_valid_q)) begin
              best_q       <= last_q;
              best_valid_q <= 1'b1;
              new_best_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      if (bus.clr_best) begin
        best_q       <= ALL9;
        best_valid_q <= 1'b0;
      end
    end
  end

  assign bus.last_bcd   = last_q;
  assign bus.best_bcd   = best_q;
  assign bus.best_valid = best_valid_q;
  assign bus.new_best   = new_best_q;
  assign bus.false_st   = false_st_q;
  assign bus.bcd_err    = bcd_err_q;
  assign bus.attempts   = attempts_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_reaction_score_keeper.sv
// Directed bench for reaction_score_keeper: drives inputs 1 time unit after each rising edge
// and checks outputs at that same point, with hand-computed expectations.
module tb_reaction_score_keeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pulses;

  reaction_score_keeper_if #(.W(24)) bus ();

  reaction_score_keeper #(
    .DIGITS(6), .MIN_TIME(24'h000100), .HIST_DEPTH(4)
  ) dut (
    .clk50M (clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Raise stop with a given time and advance until the UPDATE results are visible.
  task automatic capture(input logic [23:0] t);
    bus.time_bcd = t;
    bus.stop     = 1'b1;
    repeat (4) step();
    bus.stop     = 1'b0;
  endtask

  initial begin
    bus.stop     = 1'b0;
    bus.time_bcd = '0;
    bus.clr_best = 1'b0;
    bus.hist_sel = 3'd0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;

    chk("rst_best",     bus.best_bcd, 24'h999999);
    chk("rst_valid",    24'(bus.best_valid), 24'd0);
    chk("rst_attempts", 24'(bus.attempts), 24'd0);
    chk("rst_last",     bus.last_bcd, 24'h000000);
    chk("rst_busy",     24'(bus.busy), 24'd0);
    chk("rst_pulses",   24'({bus.new_best, bus.false_st, bus.bcd_err}), 24'd0);

    // First valid capture, with busy tracked through the sequence.
    bus.time_bcd = 24'h000250;
    bus.stop     = 1'b1;
    step();
    chk("busy_capture", 24'(bus.busy), 24'd1);
    step();
    chk("last_at_n1", bus.last_bcd, 24'h000250);
    step();
    chk("busy_update", 24'(bus.busy), 24'd1);
    step();
    bus.stop = 1'b0;
    chk("c1_best",     bus.best_bcd, 24'h000250);
    chk("c1_valid",    24'(bus.best_valid), 24'd1);
    chk("c1_new_best", 24'(bus.new_best), 24'd1);
    chk("c1_attempts", 24'(bus.attempts), 24'd1);
    chk("c1_busy",     24'(bus.busy), 24'd0);
    step();
    chk("c1_pulse_end", 24'(bus.new_best), 24'd0);

    capture(24'h000300);
    chk("c2_new_best", 24'(bus.new_best), 24'd0);
    chk("c2_best",     bus.best_bcd, 24'h000250);
    chk("c2_attempts", 24'(bus.attempts), 24'd2);
    step();

    capture(24'h000250);
    chk("c3_equal_not_best", 24'(bus.new_best), 24'd0);
    chk("c3_attempts",       24'(bus.attempts), 24'd3);
    step();

    capture(24'h000050);
    chk("fs_pulse",    24'(bus.false_st), 24'd1);
    chk("fs_attempts", 24'(bus.attempts), 24'd3);
    chk("fs_last",     bus.last_bcd, 24'h000050);
    chk("fs_best",     bus.best_bcd, 24'h000250);
    step();
    chk("fs_pulse_end", 24'(bus.false_st), 24'd0);

    capture(24'h0000A3);
    chk("err_pulse",    24'(bus.bcd_err), 24'd1);
    chk("err_no_fs",    24'(bus.false_st), 24'd0);
    chk("err_best",     bus.best_bcd, 24'h000250);
    chk("err_attempts", 24'(bus.attempts), 24'd3);
    step();

    // Level-held stop must capture only once.
    bus.time_bcd = 24'h000200;
    bus.stop     = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.new_best) pulses++;
    end
    bus.stop = 1'b0;
    chk("held_single_pulse", 24'(pulses), 24'd1);
    chk("held_attempts",     24'(bus.attempts), 24'd4);
    chk("held_best",         bus.best_bcd, 24'h000200);
    step();

    // Clear asserted during UPDATE of a valid capture.
    bus.time_bcd = 24'h000120;
    bus.stop     = 1'b1;
    repeat (3) step();
    bus.clr_best = 1'b1;
    step();
    bus.clr_best = 1'b0;
    bus.stop     = 1'b0;
    chk("clr_best",     bus.best_bcd, 24'h999999);
    chk("clr_valid",    24'(bus.best_valid), 24'd0);
    chk("clr_attempts", 24'(bus.attempts), 24'd5);
    chk("clr_no_pulse", 24'(bus.new_best), 24'd0);
    step();

    capture(24'h999999);
    chk("max_new_best", 24'(bus.new_best), 24'd1);
    chk("max_best",     bus.best_bcd, 24'h999999);
    chk("max_valid",    24'(bus.best_valid), 24'd1);
    chk("max_attempts", 24'(bus.attempts), 24'd6);
    step();

    capture(24'h000000);
    chk("zero_fs", 24'(bus.false_st), 24'd1);
    step();

    // A second rise while busy is dropped.
    bus.time_bcd = 24'h000400;
    bus.stop     = 1'b1;
    step();
    bus.stop = 1'b0;
    step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    repeat (6) step();
    chk("busy_ignore_attempts", 24'(bus.attempts), 24'd7);
    chk("busy_ignore_best",     bus.best_bcd, 24'h000400);
    chk("busy_idle",            24'(bus.busy), 24'd0);

    // History after a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      capture({16'h0000, 4'(k), 4'h0} << 4);
      step();
    end
    chk("hist_attempts", 24'(bus.attempts), 24'd5);
    chk("hist_best",     bus.best_bcd, 24'h000100);
`ifdef SCORE_HIST_EN
    bus.hist_sel = 3'd0; #1 chk("hist0", bus.hist_bcd, 24'h000500);
    bus.hist_sel = 3'd1; #1 chk("hist1", bus.hist_bcd, 24'h000400);
    bus.hist_sel = 3'd2; #1 chk("hist2", bus.hist_bcd, 24'h000300);
    bus.hist_sel = 3'd3; #1 chk("hist3", bus.hist_bcd, 24'h000200);
`else
    bus.hist_sel = 3'd0; #1 chk("hist_last0", bus.hist_bcd, 24'h000500);
    bus.hist_sel = 3'd3; #1 chk("hist_last3", bus.hist_bcd, 24'h000500);
`endif
    bus.hist_sel = 3'd0;
    step();

    // Reset while in CHECK abandons the capture.
    bus.time_bcd = 24'h000150;
    bus.stop     = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.stop = 1'b0;
    chk("midrst_busy",     24'(bus.busy), 24'd0);
    chk("midrst_attempts", 24'(bus.attempts), 24'd0);
    chk("midrst_best",     bus.best_bcd, 24'h999999);
    chk("midrst_last",     bus.last_bcd, 24'h000000);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.new_best | bus.false_st | bus.bcd_err) pulses++;
      step();
    end
    chk("midrst_no_pulses", 24'(pulses), 24'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
